// File: rtl/mem_port_arb.sv
// Shares one memory port between instruction fetch and the data load/store path.
// Latency: grants are combinational (0 cycles); read data returns MEM_LATENCY cycles after accept.
// Backpressure: mem_ready_p1 = 0 blocks all grants; a requester holds its request until granted.
//
// Ports:
//   clk, rst (async, active-low)
//   if_*   : fetch read request / grant / return path (if_flush_p1 kills in-flight fetches)
//   dm_*   : data load/store request / grant / load return path
//   mem_*  : unified memory macro port (request out, ready and read data in)
//   fetch_stall_p1 : fetch is requesting but not granted this cycle
module mem_port_arb #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_p1,
    input  logic [15:0] if_addr_p1,
    input  logic        if_flush_p1,
    output logic        if_gnt_p1,
    output logic        if_rvalid_p1,
    output logic [15:0] if_rdata_p1,

    input  logic        dm_req_p1,
    input  logic        dm_we_p1,
    input  logic [15:0] dm_addr_p1,
    input  logic [15:0] dm_wdata_p1,
    output logic        dm_gnt_p1,
    output logic        dm_rvalid_p1,
    output logic [15:0] dm_rdata_p1,

    input  logic        mem_ready_p1,
    output logic        mem_req_p1,
    output logic        mem_we_p1,
    output logic [15:0] mem_addr_p1,
    output logic [15:0] mem_wdata_p1,
    input  logic [15:0] mem_rdata_p1,

    output logic        fetch_stall_p1
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       fetch_prio;
    logic       can_issue;

    // Tag pipeline: index 1 is the youngest entry, index MEM_LATENCY is the tail
    // whose read data is on mem_rdata_p1 this cycle. owner 1 = fetch, 0 = data.
    logic [MEM_LATENCY:1]   tag_vld;
    logic [MEM_LATENCY:1]   tag_own;
    logic [MEM_LATENCY-1:0] nxt_vld;
    logic [MEM_LATENCY-1:0] nxt_own;
    logic                   tail_vld;
    logic                   tail_own;

    // Reset is folded into the combinational outputs so that nothing leaks out
    // while rst is held low, whatever the requesters are doing.
    assign fetch_prio = (starve_cnt == STARVE_MAX);
    assign can_issue  = rst & mem_ready_p1;

    // Data wins by default; a starved fetch takes the port, but never in a flush cycle.
    assign if_gnt_p1      = can_issue & if_req_p1 & ~if_flush_p1 & (fetch_prio | ~dm_req_p1);
    assign dm_gnt_p1      = can_issue & dm_req_p1 & ~if_gnt_p1;
    assign fetch_stall_p1 = rst & if_req_p1 & ~if_gnt_p1;

    always_comb begin
        mem_req_p1   = 1'b0;
        mem_we_p1    = 1'b0;
        mem_addr_p1  = '0;
        mem_wdata_p1 = '0;
        if (if_gnt_p1) begin
            mem_req_p1  = 1'b1;
            mem_addr_p1 = if_addr_p1;
        end else if (dm_gnt_p1) begin
            mem_req_p1   = 1'b1;
            mem_we_p1    = dm_we_p1;
            mem_addr_p1  = dm_addr_p1;
            mem_wdata_p1 = dm_wdata_p1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_flush_p1 || !if_req_p1 || if_gnt_p1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Next-state of the tag pipeline: slot 0 is this cycle's accept (stores push
    // an invalid entry so slots stay aligned with the memory's fixed latency);
    // older entries shift up with fetch-owned entries killed by a flush.
    always_comb begin
        nxt_vld    = '0;
        nxt_own    = '0;
        nxt_vld[0] = if_gnt_p1 | (dm_gnt_p1 & ~dm_we_p1);
        nxt_own[0] = if_gnt_p1;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            nxt_vld[i] = tag_vld[i] & ~(if_flush_p1 & tag_own[i]);
            nxt_own[i] = tag_own[i];
        end
    end

    // Same width on both sides: nxt[k] lands in tag[k+1], i.e. a one-slot shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld <= nxt_vld;
            tag_own <= nxt_own;
        end
    end

    assign tail_vld = tag_vld[MEM_LATENCY];
    assign tail_own = tag_own[MEM_LATENCY];

    // A flush in the same cycle as a fetch return suppresses that return.
    assign if_rvalid_p1 = rst & tail_vld & tail_own & ~if_flush_p1;
    assign dm_rvalid_p1 = rst & tail_vld & ~tail_own;
    assign if_rdata_p1  = if_rvalid_p1 ? mem_rdata_p1 : '0;
    assign dm_rdata_p1  = dm_rvalid_p1 ? mem_rdata_p1 : '0;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb with a behavioural memory and a return scoreboard.
// Latency: memory returns read data MEM_LATENCY cycles after an accepted read.
// Backpressure: mem_ready_p1 is driven low in one scenario to block grants.
module tb_mem_port_arb;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [15:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_ready, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fetch_stall;
    logic [70:0] all_outs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rv_cnt   = 0;
    int rv0;

    typedef struct {
        logic        own;
        logic [15:0] data;
        int          due;
    } ret_t;
    ret_t exp_q[$];

    logic [15:0] mem_arr [int];
    logic [15:0] rd_dat [16];
    logic        rd_v   [16];

    mem_port_arb #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_p1(if_req), .if_addr_p1(if_addr), .if_flush_p1(if_flush),
        .if_gnt_p1(if_gnt), .if_rvalid_p1(if_rvalid), .if_rdata_p1(if_rdata),
        .dm_req_p1(dm_req), .dm_we_p1(dm_we), .dm_addr_p1(dm_addr), .dm_wdata_p1(dm_wdata),
        .dm_gnt_p1(dm_gnt), .dm_rvalid_p1(dm_rvalid), .dm_rdata_p1(dm_rdata),
        .mem_ready_p1(mem_ready), .mem_req_p1(mem_req), .mem_we_p1(mem_we),
        .mem_addr_p1(mem_addr), .mem_wdata_p1(mem_wdata), .mem_rdata_p1(mem_rdata),
        .fetch_stall_p1(fetch_stall)
    );

    assign all_outs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                       mem_req, mem_we, mem_addr, mem_wdata, fetch_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
        return a ^ 16'hA5B5;
    endfunction

    // Behavioural memory: read data appears on mem_rdata for exactly the return cycle.
    initial begin
        for (int i = 0; i < 16; i++) begin
            rd_v[i]   = 1'b0;
            rd_dat[i] = '0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_rdata      = rd_v[cyc % 16] ? rd_dat[cyc % 16] : 16'hDEAD;
        rd_v[cyc % 16] = 1'b0;
    end

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (if_rvalid || dm_rvalid) rv_cnt++;
        if (!rst) begin
            exp_q.delete();
            check("rst_outs_zero", 32'(|all_outs), 0);
        end else begin
            if (if_flush) begin
                for (int i = exp_q.size() - 1; i >= 0; i--)
                    if (exp_q[i].own && exp_q[i].due >= cyc) exp_q.delete(i);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                ret_t e;
                e = exp_q.pop_front();
                if (e.own) begin
                    check("ret_if_rvalid", if_rvalid, 1);
                    check("ret_if_rdata", if_rdata, e.data);
                    check("ret_if_no_dm", dm_rvalid, 0);
                end else begin
                    check("ret_dm_rvalid", dm_rvalid, 1);
                    check("ret_dm_rdata", dm_rdata, e.data);
                    check("ret_dm_no_if", if_rvalid, 0);
                end
            end else begin
                check("idle_if_rvalid", if_rvalid, 0);
                check("idle_dm_rvalid", dm_rvalid, 0);
            end
            if (!if_rvalid) check("if_rdata_zero", if_rdata, 0);
            if (!dm_rvalid) check("dm_rdata_zero", dm_rdata, 0);

            check("one_gnt", 32'(if_gnt & dm_gnt), 0);
            check("stall_def", fetch_stall, 32'(if_req & ~if_gnt));
            check("mem_req_def", mem_req, 32'(if_gnt | dm_gnt));
            if (!mem_ready) check("ready_gate", 32'(if_gnt | dm_gnt), 0);
            if (if_gnt) begin
                check("if_gnt_req", if_req, 1);
                check("if_gnt_noflush", if_flush, 0);
                check("mem_if_addr", mem_addr, if_addr);
                check("mem_if_we", mem_we, 0);
                exp_q.push_back('{own: 1'b1, data: memval(if_addr), due: cyc + LAT});
                rd_dat[(cyc + LAT) % 16] = memval(if_addr);
                rd_v[(cyc + LAT) % 16]   = 1'b1;
            end
            if (dm_gnt) begin
                check("dm_gnt_req", dm_req, 1);
                check("mem_dm_addr", mem_addr, dm_addr);
                check("mem_dm_we", mem_we, dm_we);
                if (dm_we) begin
                    check("mem_dm_wdata", mem_wdata, dm_wdata);
                    mem_arr[int'(dm_addr)] = dm_wdata;
                end else begin
                    exp_q.push_back('{own: 1'b0, data: memval(dm_addr), due: cyc + LAT});
                    rd_dat[(cyc + LAT) % 16] = memval(dm_addr);
                    rd_v[(cyc + LAT) % 16]   = 1'b1;
                end
            end
            if (!(if_gnt || dm_gnt))
                check("idle_mem_zero", 32'(|{mem_req, mem_we, mem_addr, mem_wdata}), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req   = 1'b0;
        if_flush = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_wdata = '0;
    endtask

    initial begin
        // Reset with every request active: outputs must stay at zero.
        rst = 1'b0; if_req = 1'b1; if_addr = 16'h1111; if_flush = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h2222; dm_wdata = 16'h3333;
        mem_ready = 1'b1; mem_rdata = '0;
        @(negedge clk);
        check("reset_outs", 32'(|all_outs), 0);
        tick();
        rst = 1'b1;
        idle();
        tick();

        // Lone fetch.
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        check("lone_gnt", if_gnt, 1);
        check("lone_no_dm_gnt", dm_gnt, 0);
        tick(); if_req = 1'b0;
        @(negedge clk); check("lone_rv_early", if_rvalid, 0);
        tick();
        @(negedge clk);
        check("lone_rvalid", if_rvalid, 1);
        check("lone_rdata", if_rdata, 16'hA5A5);
        check("lone_no_dm_rv", dm_rvalid, 0);
        tick();
        @(negedge clk); check("lone_rv_once", if_rvalid, 0);

        // Contention: data first, fetch the next cycle; returns in the same order.
        tick();
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
        @(negedge clk);
        check("cont_dm_gnt", dm_gnt, 1);
        check("cont_if_wait", if_gnt, 0);
        check("cont_stall", fetch_stall, 1);
        tick(); dm_req = 1'b0;
        @(negedge clk); check("cont_if_gnt", if_gnt, 1);
        tick(); if_req = 1'b0;
        @(negedge clk);
        check("cont_dm_rv", dm_rvalid, 1);
        check("cont_dm_rdata", dm_rdata, 16'hA7B5);
        tick();
        @(negedge clk);
        check("cont_if_rv", if_rvalid, 1);
        check("cont_if_rdata", if_rdata, 16'hA5F5);

        // Starvation: four stalls, fetch wins the fifth cycle, counter restarts.
        tick();
        if_req = 1'b1; if_addr = 16'h0050;
        for (int k = 0; k < 6; k++) begin
            dm_req = 1'b1; dm_we = 1'b0;
            dm_addr = 16'h0400 + 16'((k < 5) ? k : 4);
            @(negedge clk);
            if (k == 4) begin
                check("starve_if_gnt", if_gnt, 1);
                check("starve_dm_wait", dm_gnt, 0);
            end else begin
                check("starve_stall", fetch_stall, 1);
                check("starve_dm_gnt", dm_gnt, 1);
            end
            tick();
        end
        idle();
        repeat (3) tick();

        // Flush kills two in-flight fetches; a data load in the flush cycle survives.
        if_req = 1'b1; if_addr = 16'h0020;
        @(negedge clk); check("fl_gnt0", if_gnt, 1);
        tick(); if_addr = 16'h0022;
        @(negedge clk); check("fl_gnt1", if_gnt, 1);
        tick();
        rv0 = rv_cnt;
        if_flush = 1'b1; if_addr = 16'h0024;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0500;
        @(negedge clk);
        check("fl_no_if_gnt", if_gnt, 0);
        check("fl_dm_gnt", dm_gnt, 1);
        check("fl_tail_killed", if_rvalid, 0);
        tick(); idle();
        @(negedge clk); check("fl_no_if_rv", if_rvalid, 0);
        tick();
        @(negedge clk); check("fl_dm_rv", dm_rvalid, 1);
        tick();
        @(negedge clk); check("fl_one_ret", rv_cnt - rv0, 1);

        // Store then load with memory not ready for two cycles.
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h1234;
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("nr_no_gnt", dm_gnt, 0);
            check("nr_no_req", mem_req, 0);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("st_gnt", dm_gnt, 1);
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 16'h1234);
        tick(); dm_we = 1'b0; dm_wdata = '0;
        @(negedge clk);
        check("ld_gnt", dm_gnt, 1);
        check("ld_we", mem_we, 0);
        tick(); dm_req = 1'b0;
        @(negedge clk); check("st_no_rv", dm_rvalid, 0);
        tick();
        @(negedge clk);
        check("ld_rvalid", dm_rvalid, 1);
        check("ld_rdata", dm_rdata, 16'h1234);

        // Reset with two reads in flight.
        tick();
        if_req = 1'b1; if_addr = 16'h0030;
        @(negedge clk); check("rm_if_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0600;
        @(negedge clk); check("rm_dm_gnt", dm_gnt, 1);
        tick();
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1;
        rv0 = rv_cnt;
        @(negedge clk); check("rm_outs_zero", 32'(|all_outs), 0);
        tick();
        @(negedge clk); check("rm_outs_zero2", 32'(|all_outs), 0);
        tick();
        rst = 1'b1; idle();
        repeat (4) tick();
        @(negedge clk); check("rm_no_ret", rv_cnt - rv0, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter that shares the single unified memory port between instruction fetch and the data load/store path of the five-stage pipeline. Sits between the fetch and mem stages and the memory macro. Grants at most one request per cycle, tracks in-flight reads through a fixed-latency tag pipeline to route return data, and guarantees fetch forward progress with a starvation counter. Also discards in-flight fetch returns on a fetch flush (branch/jump redirect).

## Interface
- MEM_LATENCY, 2: cycles from accepted request to valid mem_rdata_p1 (legal 1..8)
- STARVE_LIMIT, 4: consecutive denied fetch cycles before fetch gets priority (legal 1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_p1  in  1  fetch read request, held until granted
- if_addr_p1  in  16  fetch address
- if_flush_p1  in  1  kill all fetches accepted in earlier cycles
- if_gnt_p1  out  1  fetch request accepted this cycle
- if_rvalid_p1  out  1  fetch read data valid
- if_rdata_p1  out  16  fetch read data
- dm_req_p1  in  1  data request, held until granted
- dm_we_p1  in  1  1 = store, 0 = load
- dm_addr_p1  in  16  data address
- dm_wdata_p1  in  16  store data
- dm_gnt_p1  out  1  data request accepted this cycle
- dm_rvalid_p1  out  1  load data valid
- dm_rdata_p1  out  16  load data
- mem_ready_p1  in  1  memory can accept a request this cycle
- mem_req_p1  out  1  request to memory
- mem_we_p1  out  1  write enable to memory
- mem_addr_p1  out  16  address to memory
- mem_wdata_p1  out  16  write data to memory
- mem_rdata_p1  in  16  memory read data, valid MEM_LATENCY cycles after accept
- fetch_stall_p1  out  1  if_req_p1 & ~if_gnt_p1

## Operation
- Accept = req & gnt in same cycle; grants are combinational from current requests, mem_ready_p1, starvation state, flush.
- No grant when mem_ready_p1 = 0. Fetch never granted in a cycle with if_flush_p1 = 1.
- Priority: data wins by default; fetch wins when starve_cnt == STARVE_LIMIT. Only one grant per cycle.
- mem_req_p1/we/addr/wdata = winning requester's fields, combinational; mem_we_p1 = 0 for fetch. All zero when no grant.
- starve_cnt (4 bits): +1 per cycle with fetch_stall_p1 = 1, saturates at STARVE_LIMIT; cleared on fetch accept or when if_req_p1 = 0.
- Tag pipeline: MEM_LATENCY-deep shift register of {valid, owner}; entry pushed each cycle = {accepted read, owner}; stores push valid = 0.
- At tail: valid & owner = fetch -> if_rvalid_p1 = 1, if_rdata_p1 = mem_rdata_p1; owner = data -> dm_rvalid_p1 = 1, dm_rdata_p1 = mem_rdata_p1. rdata outputs 0 when corresponding rvalid = 0.
- Flush: clears valid on every fetch-owned entry in the pipeline (including tail) in the flush cycle; tail fetch return in the flush cycle is suppressed (if_rvalid_p1 = 0). Data entries unaffected.
- Flush resets starve_cnt to 0.

## Timing
- Reset (rst = 0): tag pipeline cleared, starve_cnt = 0; all outputs 0 while reset asserted regardless of inputs. Reset mid-operation drops all in-flight returns; no rvalid after release for pre-reset requests.
- Grant latency 0: gnt in same cycle as req if it wins.
- Read data latency: request accepted at cycle T -> rvalid at T+MEM_LATENCY, exactly one cycle.
- Back-to-back: one accept per cycle sustained; returns emerge in accept order, one per cycle.
- Simultaneous req, starve_cnt < STARVE_LIMIT: dm granted, fetch stalls, starve_cnt increments.
- Simultaneous flush and data req: data may be granted; fetch not.
- Worst-case fetch wait with continuous data traffic: STARVE_LIMIT cycles of stall, granted in cycle STARVE_LIMIT+1 (if mem_ready_p1 = 1).

## Test plan
- Lone fetch: if_req=1 addr 0x0010, mem returns 0xA5A5 -> if_gnt same cycle, if_rvalid=1 with 0xA5A5 exactly 2 cycles later, dm_rvalid never.
- Contention: if_req and dm_req (load 0x0200) both held -> dm granted first, fetch granted next cycle; returns arrive dm then if on consecutive cycles.
- Starvation: dm_req held every cycle with new addresses, if_req held -> fetch_stall_p1 high 4 cycles, if_gnt in 5th, starve_cnt back to 0.
- Flush: fetches to 0x0020, 0x0022 accepted back-to-back, if_flush pulsed the cycle after second accept -> neither produces if_rvalid; fetch in flush cycle not granted.
- Store then load: dm store 0x0300=0x1234, next dm load 0x0300 -> no rvalid for store, dm_rvalid with memory value 2 cycles after load accept; mem_ready=0 cycles insert no grants.
- Reset mid-flight: assert rst low with 2 reads in flight -> all outputs 0 immediately, no rvalid after release.
